// File: rtl/prbs_checker.sv
// Self-synchronising checker for the Fibonacci LFSR word stream. It hunts for
// a clean run of predicted words, then free-runs its predictor and counts deviations.
module prbs_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] poly_i,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam int MAX_CNT = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] LOCK_TGT   = CW'(LOCK_CNT);
    localparam logic [CW-1:0] UNLOCK_TGT = CW'(UNLOCK_CNT);

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  prev_valid;
    logic [CW-1:0]         match_cnt;
    logic [CW-1:0]         miss_cnt;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  err_cnt;

    logic [DATA_WIDTH-1:0] pred_data;
    logic [DATA_WIDTH-1:0] pred_exp;
    logic                  is_match;
    logic                  is_miss;

    function automatic logic [DATA_WIDTH-1:0] predict(
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] poly
    );
        return {x[DATA_WIDTH-2:0], ^(x & poly)};
    endfunction

    // An all-zero word is the LFSR lock-up state and never counts toward lock.
    always_comb begin
        pred_data = predict(data_i, poly_i);
        pred_exp  = predict(exp_q, poly_i);
        is_match  = prev_valid && (data_i == exp_q) && (data_i != '0);
        is_miss   = (data_i != exp_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= HUNT;
            exp_q      <= '0;
            prev_valid <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            err_q      <= 1'b0;
            err_cnt    <= '0;
        end else if (clear_i) begin
            state      <= HUNT;
            exp_q      <= '0;
            prev_valid <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            err_q      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_q <= 1'b0;
            if (valid_i) begin
                if (state == HUNT) begin
                    exp_q      <= pred_data;
                    prev_valid <= 1'b1;
                    if (is_match) begin
                        if (match_cnt + CW'(1) == LOCK_TGT) begin
                            state     <= LOCKED;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + CW'(1);
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    // Locked: the predictor free-runs so a corrupted word cannot poison it.
                    if (is_miss) begin
                        err_q <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + CNT_WIDTH'(1);
                        end
                        if (miss_cnt + CW'(1) == UNLOCK_TGT) begin
                            state      <= HUNT;
                            match_cnt  <= '0;
                            miss_cnt   <= '0;
                            exp_q      <= pred_data;
                            prev_valid <= 1'b1;
                        end else begin
                            miss_cnt <= miss_cnt + CW'(1);
                            exp_q    <= pred_exp;
                        end
                    end else begin
                        miss_cnt <= '0;
                        exp_q    <= pred_exp;
                    end
                end
            end
        end
    end

    assign locked_o  = (state == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance and a 3-bit-counter instance
// share all inputs so saturation can be observed alongside the normal count.
module tb_prbs_checker;

    localparam int W = 16;
    localparam logic [W-1:0] POLY = 16'hB400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn_i;
    logic         clear_i;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic [W-1:0] poly_i;
    logic         locked;
    logic         err;
    logic [31:0]  err_cnt;
    logic         locked_s;
    logic         err_s;
    logic [2:0]   err_cnt_s;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] gen;

    prbs_checker #(.DATA_WIDTH(W), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .poly_i(poly_i),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt)
    );

    prbs_checker #(.DATA_WIDTH(W), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_WIDTH(3)) dut_s (
        .clk_i(clk), .rstn_i(rstn_i), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .poly_i(poly_i),
        .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s)
    );

    // Reference generator step.
    function automatic logic [W-1:0] gen_next(input logic [W-1:0] x);
        return {x[W-2:0], ^(x & POLY)};
    endfunction

    // Drive one cycle; outputs are sampled 1 time unit after the active edge.
    task automatic send(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_gen();
        send(1'b1, gen);
        gen = gen_next(gen);
    endtask

    task automatic send_bad(input logic [W-1:0] flip);
        send(1'b1, gen ^ flip);
        gen = gen_next(gen);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    // Nine accepted words: one seed plus eight matches; lock appears after the ninth.
    task automatic lock_up(input string tag);
        for (int i = 1; i <= 9; i++) begin
            send_gen();
            n_vec++;
            if (i < 9 && locked !== 1'b0) begin
                n_err++;
                $display("FAIL %s early_lock word %0d: locked=%b want 0", tag, i, locked);
            end
            if (i == 9 && locked !== 1'b1) begin
                n_err++;
                $display("FAIL %s lock word 9: locked=%b want 1", tag, locked);
            end
        end
    endtask

    task automatic test_reset();
        rstn_i  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        poly_i  = POLY;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({locked, err, err_cnt} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outputs: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_cnt);
        end
        n_vec++;
        if ({locked_s, err_s, err_cnt_s} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_outputs_sat: locked=%b err=%b cnt=%0d want 0/0/0", locked_s, err_s, err_cnt_s);
        end
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    task automatic test_lock_in();
        int err_seen;
        int unlock_seen;
        err_seen = 0;
        unlock_seen = 0;
        gen = 16'hACE1;
        lock_up("lock_in");
        for (int i = 0; i < 1000; i++) begin
            send_gen();
            if (err !== 1'b0) err_seen++;
            if (locked !== 1'b1) unlock_seen++;
        end
        n_vec++;
        if (err_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL lock_in_cnt: err_cnt=%0d want 0", err_cnt);
        end
        n_vec++;
        if (err_seen !== 0 || unlock_seen !== 0) begin
            n_err++;
            $display("FAIL lock_in_stable: err pulses=%0d unlocked cycles=%0d want 0/0", err_seen, unlock_seen);
        end
    endtask

    task automatic test_single_error();
        send_bad(16'h0001);
        n_vec++;
        if ({locked, err, err_cnt} !== {1'b1, 1'b1, 32'd1}) begin
            n_err++;
            $display("FAIL single_err_hit: locked=%b err=%b cnt=%0d want 1/1/1", locked, err, err_cnt);
        end
        send_gen();
        n_vec++;
        if ({locked, err, err_cnt} !== {1'b1, 1'b0, 32'd1}) begin
            n_err++;
            $display("FAIL single_err_after: locked=%b err=%b cnt=%0d want 1/0/1", locked, err, err_cnt);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = gen;
        gen     = gen_next(gen);
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        n_vec++;
        if ({locked, err, err_cnt} !== 34'd0) begin
            n_err++;
            $display("FAIL clear_outputs: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_cnt);
        end
        // The word presented with clear must not act as a seed.
        lock_up("after_clear");
    endtask

    task automatic test_loss_of_lock();
        for (int i = 1; i <= 4; i++) begin
            send_bad(16'hFFFF);
            n_vec++;
            if (err !== 1'b1 || err_cnt !== 32'(i) || locked !== (i < 4)) begin
                n_err++;
                $display("FAIL loss_bad %0d: locked=%b err=%b cnt=%0d want %b/1/%0d", i, locked, err, err_cnt, (i < 4), i);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            send_gen();
            n_vec++;
            if (err !== 1'b0 || err_cnt !== 32'd4 || locked !== (i == 9)) begin
                n_err++;
                $display("FAIL relock word %0d: locked=%b err=%b cnt=%0d want %b/0/4", i, locked, err, err_cnt, (i == 9));
            end
        end
    endtask

    task automatic test_gaps();
        int bubbles;
        do_clear();
        for (int i = 1; i <= 9; i++) begin
            send_gen();
            n_vec++;
            if (locked !== (i == 9)) begin
                n_err++;
                $display("FAIL gaps_lock word %0d: locked=%b want %b", i, locked, (i == 9));
            end
            bubbles = $urandom_range(0, 3);
            for (int b = 0; b < bubbles; b++) begin
                send(1'b0, W'($urandom));
                n_vec++;
                if (err !== 1'b0 || locked !== (i == 9)) begin
                    n_err++;
                    $display("FAIL gaps_bubble after word %0d: locked=%b err=%b want %b/0", i, locked, err, (i == 9));
                end
            end
        end
    endtask

    task automatic test_zeros();
        int bad;
        bad = 0;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 16'h0000);
            if (locked !== 1'b0 || err !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL zeros: bad cycles=%0d want 0 (locked=%b err=%b)", bad, locked, err);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        lock_up("sat_lock");
        for (int i = 0; i < 10; i++) begin
            send_bad(16'h0001);
            send_gen();
        end
        n_vec++;
        if (err_cnt_s !== 3'd7 || locked_s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_cnt: cnt=%0d locked=%b want 7/1", err_cnt_s, locked_s);
        end
        n_vec++;
        if (err_cnt !== 32'd10 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL wide_cnt: cnt=%0d locked=%b want 10/1", err_cnt, locked);
        end
        test_clear();
        n_vec++;
        if (err_cnt_s !== 3'd0 || locked_s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_after_clear: cnt=%0d locked=%b want 0/1", err_cnt_s, locked_s);
        end
    endtask

    task automatic test_async_reset();
        send_bad(16'h0001);
        #3;
        rstn_i = 1'b0;
        #1;
        n_vec++;
        if ({locked, err, err_cnt} !== 34'd0) begin
            n_err++;
            $display("FAIL async_reset: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        lock_up("after_async_reset");
    endtask

    initial begin
        test_reset();
        test_lock_in();
        test_single_error();
        test_clear();
        test_loss_of_lock();
        test_gaps();
        test_zeros();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
